// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronise, glitch-filter and Gray-decode a quadrature encoder into step/direction pulses.
//   clk, reset (async, active-low) | a_in, b_in raw channels | clr_err clears err_cnt
//   E step pulse, F direction (1 = forward), err illegal-transition pulse, err_cnt saturating count,
//   ab_state filtered {A,B}, armed high once warm-up is done
module quad_step_decoder #(
  parameter int FILT_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_err,
  output logic             E,
  output logic             F,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       ab_state,
  output logic             armed
);
  typedef enum logic {WARMUP, RUN} state_t;
  localparam logic [2:0] FC_LAST = 3'(FILT_CYCLES - 1);
  localparam logic [3:0] WU_LAST = 4'(FILT_CYCLES + 2);
  state_t          r_state, w_next;
  logic [1:0]      r_s1, r_s2, r_filt, r_prev;
  logic [1:0][2:0] r_fcnt;
  logic [3:0]      r_wcnt;
  logic [1:0]      w_pos_new, w_pos_old, w_delta;
  logic            w_step, w_dbl;
  assign ab_state  = r_filt;
  assign armed     = r_state == RUN;
  // Map Gray code to its position on the forward cycle 00,01,11,10 so the
  // step distance is a plain 2-bit difference: 1 = forward, 3 = reverse, 2 = double.
  assign w_pos_new = {r_filt[1], r_filt[1] ^ r_filt[0]};
  assign w_pos_old = {r_prev[1], r_prev[1] ^ r_prev[0]};
  assign w_delta   = w_pos_new - w_pos_old;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      r_fcnt <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= {a_in, b_in};
      r_s2   <= r_s1;
      r_prev <= r_filt;
      for (int i = 0; i < 2; i++)
        if (r_s2[i] == r_filt[i]) r_fcnt[i] <= '0;
        else if (r_fcnt[i] == FC_LAST) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else r_fcnt[i] <= r_fcnt[i] + 3'd1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= WARMUP;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= r_state == WARMUP ? r_wcnt + 4'd1 : r_wcnt;
    end
  // Warm-up spans the synchroniser, filter and prev-tracking latency so a
  // non-idle encoder position at reset release settles without decoding.
  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    w_dbl  = 1'b0;
    if (r_state == WARMUP) w_next = r_wcnt == WU_LAST ? RUN : WARMUP;
    else begin
      w_step = w_delta[0];
      w_dbl  = w_delta == 2'd2;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      E       <= 1'b0;
      F       <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      E       <= w_step;
      err     <= w_dbl;
      F       <= w_step ? ~w_delta[1] : F;
      err_cnt <= clr_err ? ERR_W'(w_dbl) : (w_dbl && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
    end
endmodule
